// File: rtl/oam_dma_controller.sv
// Copies a 256-byte CPU page into PPU OAMDATA: a trigger write halts the CPU, then alternates
// a memory read and a PPU write per byte; outputs are registered, DONE pulses once after byte 255.
module oam_dma_controller #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_SEL  = 3'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_IN,
  input  logic        CPU_wren,
  input  logic [7:0]  MEM_DATA_IN,
  output logic        CPU_HALT,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_rden,
  output logic [2:0]  PPU_ADDR_OUT,
  output logic [7:0]  PPU_DATA_OUT,
  output logic        PPU_wren,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, WAIT_RD, DUMMY, ALIGN, READ, WRITE} state_t;

  state_t     state;
  logic [7:0] page;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       parity;
  logic       trigger;

  assign cnt_inc = cnt + 8'd1;
  assign trigger = CPU_wren && (CPU_ADDR == TRIGGER_ADDR);

  // Read data arrives one cycle after DMA_rden, i.e. exactly in the WRITE cycle.
  assign PPU_DATA_OUT = PPU_wren ? MEM_DATA_IN : 8'h00;

  // Outputs are set on the edge entering the state they belong to, so they are valid
  // for the whole of that state without any output decode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      page         <= 8'h00;
      cnt          <= 8'h00;
      parity       <= 1'b0;
      CPU_HALT     <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      DMA_rden     <= 1'b0;
      DMA_ADDR     <= 16'h0000;
      PPU_wren     <= 1'b0;
      PPU_ADDR_OUT <= 3'd0;
    end else begin
      parity       <= ~parity;
      DONE         <= 1'b0;
      DMA_rden     <= 1'b0;
      DMA_ADDR     <= 16'h0000;
      PPU_wren     <= 1'b0;
      PPU_ADDR_OUT <= 3'd0;
      case (state)
        IDLE: begin
          if (trigger) begin
            page     <= CPU_DATA_IN;
            cnt      <= 8'h00;
            state    <= WAIT_RD;
            CPU_HALT <= 1'b1;
            BUSY     <= 1'b1;
          end
        end
        WAIT_RD: begin
          // The halt only takes effect once the CPU is on a read cycle.
          if (!CPU_wren) state <= DUMMY;
        end
        DUMMY: begin
          if (parity) begin
            state <= ALIGN;
          end else begin
            state    <= READ;
            DMA_rden <= 1'b1;
            DMA_ADDR <= {page, cnt};
          end
        end
        ALIGN: begin
          state    <= READ;
          DMA_rden <= 1'b1;
          DMA_ADDR <= {page, cnt};
        end
        READ: begin
          state        <= WRITE;
          PPU_wren     <= 1'b1;
          PPU_ADDR_OUT <= OAMDATA_SEL;
        end
        WRITE: begin
          cnt <= cnt_inc;
          if (cnt == 8'hFF) begin
            state    <= IDLE;
            DONE     <= 1'b1;
            CPU_HALT <= 1'b0;
            BUSY     <= 1'b0;
          end else begin
            state    <= READ;
            DMA_rden <= 1'b1;
            DMA_ADDR <= {page, cnt_inc};
          end
        end
        default: begin
          state    <= IDLE;
          CPU_HALT <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: stimulus queues expected events, a negedge monitor pops them.
module tb_oam_dma_controller;

  localparam logic [15:0] TRIG = 16'h4014;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_DATA_IN;
  logic        CPU_wren;
  logic [7:0]  MEM_DATA_IN = 8'hA5;
  logic        CPU_HALT;
  logic [15:0] DMA_ADDR;
  logic        DMA_rden;
  logic [2:0]  PPU_ADDR_OUT;
  logic [7:0]  PPU_DATA_OUT;
  logic        PPU_wren;
  logic        BUSY;
  logic        DONE;

  oam_dma_controller dut (
    .CLK(CLK), .RESET(RESET), .CPU_ADDR(CPU_ADDR), .CPU_DATA_IN(CPU_DATA_IN),
    .CPU_wren(CPU_wren), .MEM_DATA_IN(MEM_DATA_IN), .CPU_HALT(CPU_HALT),
    .DMA_ADDR(DMA_ADDR), .DMA_rden(DMA_rden), .PPU_ADDR_OUT(PPU_ADDR_OUT),
    .PPU_DATA_OUT(PPU_DATA_OUT), .PPU_wren(PPU_wren), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Memory returns the low address byte one cycle after a read strobe, junk otherwise.
  always @(posedge CLK) MEM_DATA_IN <= DMA_rden ? DMA_ADDR[7:0] : 8'hA5;

  // Reference parity: cleared by reset, toggles every cycle.
  logic tb_par = 1'b0;
  always @(posedge CLK) tb_par <= RESET ? 1'b0 : ~tb_par;

  typedef enum int {EV_FIRST, EV_RD, EV_WR, EV_DONE, EV_HALT, EV_BUSY} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 0;

  task automatic expect_ev(input ev_kind_t k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_t k, input int act, input string name);
    ev_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: got unexpected event value 0x%0h, scoreboard empty", name, act);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != act) begin
        n_err++;
        $display("FAIL %s: got %s 0x%0h, expected %s 0x%0h", name, k.name(), act, e.kind.name(), e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  int halt_run = 0;
  int busy_run = 0;
  bit rd_seen  = 0;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (DMA_rden) begin
        if (!rd_seen) begin
          check_ev(EV_FIRST, halt_run, "first_read_delay");
          rd_seen = 1;
        end
        check_ev(EV_RD, int'(DMA_ADDR), "dma_read");
      end else begin
        chk("dma_addr_idle", int'(DMA_ADDR), 0);
      end
      if (PPU_wren) check_ev(EV_WR, int'({PPU_ADDR_OUT, PPU_DATA_OUT}), "ppu_write");
      else chk("ppu_idle", int'({PPU_ADDR_OUT, PPU_DATA_OUT}), 0);
      if (DONE) check_ev(EV_DONE, 1, "done_pulse");
      if (!CPU_HALT && halt_run > 0) begin
        check_ev(EV_HALT, halt_run, "halt_length");
        halt_run = 0;
        rd_seen  = 0;
      end
      if (!BUSY && busy_run > 0) begin
        check_ev(EV_BUSY, busy_run, "busy_length");
        busy_run = 0;
      end
      if (CPU_HALT) halt_run++;
      if (BUSY) busy_run++;
    end
  end

  // One DMA: want_par -1 = take parity as found; retrig_at/abort_after -1 = unused.
  task automatic xfer(input logic [7:0] page, input int hold, input int want_par,
                      input int retrig_at, input int abort_after);
    int  align;
    int  nbytes;
    int  cyc;
    int  wr;
    bit  finished;
    if (want_par >= 0)
      for (int i = 0; i < 4 && int'(tb_par ^ hold[0]) != want_par; i++) @(negedge CLK);
    align  = int'(tb_par ^ hold[0]);
    nbytes = (abort_after >= 0) ? abort_after : 256;
    expect_ev(EV_FIRST, hold + 2 + align);
    for (int i = 0; i < nbytes; i++) begin
      expect_ev(EV_RD, int'({page, 8'(i)}));
      expect_ev(EV_WR, (4 << 8) | i);
    end
    if (abort_after < 0) begin
      expect_ev(EV_DONE, 1);
      expect_ev(EV_HALT, hold + 1 + 513 + align);
      expect_ev(EV_BUSY, hold + 1 + 513 + align);
    end else begin
      expect_ev(EV_HALT, hold + 2 + align + 2 * abort_after);
      expect_ev(EV_BUSY, hold + 2 + align + 2 * abort_after);
    end
    CPU_ADDR    = TRIG;
    CPU_DATA_IN = page;
    CPU_wren    = 1'b1;
    @(negedge CLK);
    repeat (hold) @(negedge CLK);
    CPU_wren = 1'b0;
    CPU_ADDR = 16'h0000;
    cyc      = 0;
    wr       = 0;
    finished = 0;
    while (!finished && cyc < 700) begin
      @(negedge CLK);
      cyc++;
      if (cyc == retrig_at) begin
        CPU_ADDR    = TRIG;
        CPU_DATA_IN = 8'h77;
        CPU_wren    = 1'b1;
      end else if (cyc == retrig_at + 1) begin
        CPU_wren = 1'b0;
        CPU_ADDR = 16'h0000;
      end
      if (PPU_wren) wr++;
      if (abort_after >= 0 && wr == abort_after) begin
        RESET       = 1'b1;
        CPU_ADDR    = TRIG;
        CPU_DATA_IN = 8'h33;
        CPU_wren    = 1'b1;
        @(negedge CLK);
        RESET    = 1'b0;
        CPU_wren = 1'b0;
        CPU_ADDR = 16'h0000;
        finished = 1;
      end else if (DONE) begin
        finished = 1;
      end
    end
    if (!finished) begin
      n_vec++;
      n_err++;
      $display("FAIL xfer_timeout: page 0x%0h did not finish within %0d cycles", page, cyc);
    end
  endtask

  initial begin
    RESET       = 1'b1;
    CPU_ADDR    = 16'h0000;
    CPU_DATA_IN = 8'h00;
    CPU_wren    = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_halt", int'(CPU_HALT), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_rden", int'(DMA_rden), 0);
    chk("reset_dma_addr", int'(DMA_ADDR), 0);
    chk("reset_ppu", int'({PPU_wren, PPU_ADDR_OUT, PPU_DATA_OUT}), 0);
    RESET  = 1'b0;
    mon_en = 1;
    repeat (2) @(negedge CLK);

    xfer(8'h02, 0, 0, -1, -1);
    repeat (3) @(negedge CLK);
    xfer(8'h03, 0, 1, -1, -1);
    repeat (2) @(negedge CLK);
    xfer(8'h11, 3, -1, -1, -1);
    // Trigger issued in the DONE cycle of the previous transfer.
    xfer(8'hFF, 0, -1, -1, -1);
    repeat (4) @(negedge CLK);
    xfer(8'h05, 1, -1, 50, -1);
    repeat (3) @(negedge CLK);
    xfer(8'h40, 0, -1, -1, 100);
    repeat (3) @(negedge CLK);

    // Reset wins over a trigger in the same cycle while idle.
    RESET       = 1'b1;
    CPU_ADDR    = TRIG;
    CPU_DATA_IN = 8'h09;
    CPU_wren    = 1'b1;
    @(negedge CLK);
    RESET    = 1'b0;
    CPU_wren = 1'b0;
    CPU_ADDR = 16'h0000;
    repeat (8) @(negedge CLK);
    chk("idle_after_reset_trigger", int'({CPU_HALT, BUSY}), 0);

    xfer(8'h01, 0, 1, -1, -1);
    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
